// File: rtl/tensor_core_burst_sequencer.sv
// Burst transfer engine between a streaming bus and the tensor core register file.
// Independent write and read channels with valid/ready handshakes, abort and error pulse.
module tensor_core_burst_sequencer #(
    parameter int unsigned DATA_WIDTH   = 8,
    parameter int unsigned MATRIX_DIM   = 3,
    parameter int unsigned NUM_MATRICES = 2,
    parameter int unsigned LANES        = 2,
    parameter int unsigned ADDR_WIDTH   = 5
) (
    input  logic                          clock_in,
    input  logic                          reset_in,
    input  logic                          start_in,
    input  logic [1:0]                    mode_in,
    input  logic                          abort_in,
    input  logic                          in_valid_in,
    input  logic [LANES*DATA_WIDTH-1:0]   in_data_in,
    output logic                          in_ready_out,
    output logic [LANES-1:0]              rf_write_enable_out,
    output logic [LANES*ADDR_WIDTH-1:0]   rf_write_address_out,
    output logic [LANES*DATA_WIDTH-1:0]   rf_write_data_out,
    output logic [LANES*ADDR_WIDTH-1:0]   rf_read_address_out,
    input  logic [LANES*DATA_WIDTH-1:0]   rf_read_data_in,
    output logic                          out_valid_out,
    input  logic                          out_ready_in,
    output logic [LANES*DATA_WIDTH-1:0]   out_data_out,
    output logic                          busy_out,
    output logic                          done_out,
    output logic                          error_out
);

    localparam int unsigned WRITE_ELEMS = NUM_MATRICES * MATRIX_DIM * MATRIX_DIM;
    localparam int unsigned WRITE_BEATS = (WRITE_ELEMS + LANES - 1) / LANES;
    localparam int unsigned READ_ELEMS  = MATRIX_DIM * MATRIX_DIM;
    localparam int unsigned READ_BEATS  = (READ_ELEMS + LANES - 1) / LANES;
    localparam int unsigned MAX_BEATS   = (WRITE_BEATS > READ_BEATS) ? WRITE_BEATS : READ_BEATS;
    localparam int unsigned BEAT_W      = (MAX_BEATS < 2) ? 1 : $clog2(MAX_BEATS + 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                wr_en_q, wr_en_d;
    logic                rd_en_q, rd_en_d;
    logic                wr_fin_q, wr_fin_d;
    logic                rd_fin_q, rd_fin_d;
    logic [BEAT_W-1:0]   wr_beat_q, wr_beat_d;
    logic [BEAT_W-1:0]   rd_beat_q, rd_beat_d;
    logic                done_q, done_d;
    logic                error_q, error_d;

    logic                active;
    logic                wr_acc;
    logic                rd_acc;

    assign active    = (state_q == ST_ACTIVE);
    assign busy_out  = active;
    assign done_out  = done_q;
    assign error_out = error_q;
    assign wr_acc    = in_valid_in && in_ready_out;
    assign rd_acc    = out_valid_out && out_ready_in;

    // Beat-level datapath: handshakes, per-lane addresses and data, all gated by state.
    always_comb begin
        in_ready_out         = active && wr_en_q && !wr_fin_q && !abort_in;
        out_valid_out        = active && rd_en_q && !rd_fin_q && !abort_in;
        rf_write_enable_out  = '0;
        rf_write_address_out = '0;
        rf_write_data_out    = (active && wr_en_q) ? in_data_in : '0;
        rf_read_address_out  = '0;
        out_data_out         = '0;
        for (int unsigned l = 0; l < LANES; l++) begin
            int unsigned w_elem;
            int unsigned r_elem;
            w_elem = 32'(wr_beat_q) * LANES + l;
            r_elem = 32'(rd_beat_q) * LANES + l;
            if (active && wr_en_q && (w_elem < WRITE_ELEMS)) begin
                rf_write_address_out[l*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(w_elem);
                rf_write_enable_out[l] = in_valid_in && in_ready_out;
            end
            // Lanes past the result matrix read address 0 and return zero data.
            if (active && rd_en_q && (r_elem < READ_ELEMS)) begin
                rf_read_address_out[l*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(r_elem);
                out_data_out[l*DATA_WIDTH +: DATA_WIDTH] = rf_read_data_in[l*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

    // Next-state logic for the burst FSM and channel counters.
    always_comb begin
        state_d   = state_q;
        wr_en_d   = wr_en_q;
        rd_en_d   = rd_en_q;
        wr_fin_d  = wr_fin_q;
        rd_fin_d  = rd_fin_q;
        wr_beat_d = wr_beat_q;
        rd_beat_d = rd_beat_q;
        done_d    = (state_q == ST_DONE);
        error_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                wr_beat_d = '0;
                rd_beat_d = '0;
                if (start_in && !abort_in) begin
                    if (mode_in == 2'b11) begin
                        error_d = 1'b1;
                    end else begin
                        state_d  = ST_ACTIVE;
                        rd_en_d  = (mode_in != 2'b01);
                        wr_en_d  = (mode_in != 2'b00);
                        wr_fin_d = 1'b0;
                        rd_fin_d = 1'b0;
                    end
                end
            end
            ST_ACTIVE: begin
                if (abort_in) begin
                    state_d   = ST_IDLE;
                    wr_en_d   = 1'b0;
                    rd_en_d   = 1'b0;
                    wr_fin_d  = 1'b0;
                    rd_fin_d  = 1'b0;
                    wr_beat_d = '0;
                    rd_beat_d = '0;
                end else begin
                    if (wr_acc) begin
                        wr_beat_d = wr_beat_q + BEAT_W'(1);
                        if (wr_beat_q == BEAT_W'(WRITE_BEATS - 1)) begin
                            wr_fin_d = 1'b1;
                        end
                    end
                    if (rd_acc) begin
                        rd_beat_d = rd_beat_q + BEAT_W'(1);
                        if (rd_beat_q == BEAT_W'(READ_BEATS - 1)) begin
                            rd_fin_d = 1'b1;
                        end
                    end
                    if ((!wr_en_q || wr_fin_d) && (!rd_en_q || rd_fin_d)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                state_d   = ST_IDLE;
                wr_en_d   = 1'b0;
                rd_en_d   = 1'b0;
                wr_fin_d  = 1'b0;
                rd_fin_d  = 1'b0;
                wr_beat_d = '0;
                rd_beat_d = '0;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock_in or posedge reset_in) begin
        if (reset_in) begin
            state_q   <= ST_IDLE;
            wr_en_q   <= 1'b0;
            rd_en_q   <= 1'b0;
            wr_fin_q  <= 1'b0;
            rd_fin_q  <= 1'b0;
            wr_beat_q <= '0;
            rd_beat_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_en_q   <= wr_en_d;
            rd_en_q   <= rd_en_d;
            wr_fin_q  <= wr_fin_d;
            rd_fin_q  <= rd_fin_d;
            wr_beat_q <= wr_beat_d;
            rd_beat_q <= rd_beat_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

endmodule

// File: tb/tb_tensor_core_burst_sequencer.sv
// Directed bench for tensor_core_burst_sequencer at default parameters (3x3, 2 matrices, 2 lanes).
module tb_tensor_core_burst_sequencer;

    logic        clock_in = 1'b0;
    logic        reset_in = 1'b1;
    logic        start_in = 1'b0;
    logic [1:0]  mode_in = 2'b00;
    logic        abort_in = 1'b0;
    logic        in_valid_in = 1'b0;
    logic [15:0] in_data_in = '0;
    logic        in_ready_out;
    logic [1:0]  rf_write_enable_out;
    logic [9:0]  rf_write_address_out;
    logic [15:0] rf_write_data_out;
    logic [9:0]  rf_read_address_out;
    logic [15:0] rf_read_data_in;
    logic        out_valid_out;
    logic        out_ready_in = 1'b0;
    logic [15:0] out_data_out;
    logic        busy_out;
    logic        done_out;
    logic        error_out;

    int total = 0;
    int bad = 0;

    typedef struct {
        logic        start;
        logic [1:0]  mode;
        logic        in_valid;
        logic [15:0] in_data;
        logic        exp_ready;
        logic [1:0]  exp_we;
        logic [9:0]  exp_waddr;
        logic [15:0] exp_wdata;
        logic        exp_busy;
        logic        exp_done;
    } vec_t;

    vec_t wtab[12];

    // Result matrix register file model: element at address a holds a+10.
    logic [4:0] ra0, ra1;
    assign ra0 = rf_read_address_out[4:0];
    assign ra1 = rf_read_address_out[9:5];
    assign rf_read_data_in = {8'(ra1) + 8'd10, 8'(ra0) + 8'd10};

    int rd_a0[5] = '{0, 2, 4, 6, 8};
    int rd_a1[5] = '{1, 3, 5, 7, 0};
    int rd_d0[5] = '{10, 12, 14, 16, 18};
    int rd_d1[5] = '{11, 13, 15, 17, 0};

    tensor_core_burst_sequencer dut (
        .clock_in            (clock_in),
        .reset_in            (reset_in),
        .start_in            (start_in),
        .mode_in             (mode_in),
        .abort_in            (abort_in),
        .in_valid_in         (in_valid_in),
        .in_data_in          (in_data_in),
        .in_ready_out        (in_ready_out),
        .rf_write_enable_out (rf_write_enable_out),
        .rf_write_address_out(rf_write_address_out),
        .rf_write_data_out   (rf_write_data_out),
        .rf_read_address_out (rf_read_address_out),
        .rf_read_data_in     (rf_read_data_in),
        .out_valid_out       (out_valid_out),
        .out_ready_in        (out_ready_in),
        .out_data_out        (out_data_out),
        .busy_out            (busy_out),
        .done_out            (done_out),
        .error_out           (error_out)
    );

    always #5 clock_in = ~clock_in;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_busy"}, 32'(busy_out), 32'd0);
        chk({name, "_done"}, 32'(done_out), 32'd0);
        chk({name, "_error"}, 32'(error_out), 32'd0);
        chk({name, "_in_ready"}, 32'(in_ready_out), 32'd0);
        chk({name, "_out_valid"}, 32'(out_valid_out), 32'd0);
        chk({name, "_we"}, 32'(rf_write_enable_out), 32'd0);
        chk({name, "_waddr"}, 32'(rf_write_address_out), 32'd0);
        chk({name, "_wdata"}, 32'(rf_write_data_out), 32'd0);
        chk({name, "_raddr"}, 32'(rf_read_address_out), 32'd0);
        chk({name, "_odata"}, 32'(out_data_out), 32'd0);
    endtask

    function automatic logic [15:0] wpack(input int b);
        return {8'(2 * b + 2), 8'(2 * b + 1)};
    endfunction

    function automatic logic [9:0] waddr_exp(input int b);
        return {5'(2 * b + 1), 5'(2 * b)};
    endfunction

    function automatic logic [9:0] raddr_exp(input int b);
        if (b >= 5) return '0;
        return {5'(rd_a1[b]), 5'(rd_a0[b])};
    endfunction

    function automatic logic [15:0] odata_exp(input int b);
        if (b >= 5) return '0;
        return {8'(rd_d1[b]), 8'(rd_d0[b])};
    endfunction

    initial begin
        int eb, hs, dcount, dcyc, wb, rb;
        logic [15:0] wd;

        // Write burst, cycle 0 = start cycle; beats accepted in cycles 1..9.
        for (int c = 0; c < 12; c++) begin
            int b;
            logic beat;
            b = c - 1;
            beat = (c >= 1) && (c <= 9);
            wtab[c].start     = (c == 0);
            wtab[c].mode      = 2'b01;
            wtab[c].in_valid  = 1'b1;
            wtab[c].in_data   = beat ? wpack(b) : 16'h0;
            wtab[c].exp_ready = beat;
            wtab[c].exp_we    = beat ? 2'b11 : 2'b00;
            wtab[c].exp_waddr = beat ? waddr_exp(b) : 10'h0;
            wtab[c].exp_wdata = beat ? wpack(b) : 16'h0;
            wtab[c].exp_busy  = beat;
            wtab[c].exp_done  = (c == 11);
        end

        repeat (2) @(negedge clock_in);
        #1 chk_zero("reset");
        @(negedge clock_in);
        reset_in = 1'b0;
        #1 chk_zero("after_reset");

        for (int c = 0; c < 12; c++) begin
            @(negedge clock_in);
            start_in    = wtab[c].start;
            mode_in     = wtab[c].mode;
            in_valid_in = wtab[c].in_valid;
            in_data_in  = wtab[c].in_data;
            #1;
            chk("wr_ready", 32'(in_ready_out), 32'(wtab[c].exp_ready));
            chk("wr_we", 32'(rf_write_enable_out), 32'(wtab[c].exp_we));
            chk("wr_waddr", 32'(rf_write_address_out), 32'(wtab[c].exp_waddr));
            chk("wr_wdata", 32'(rf_write_data_out), 32'(wtab[c].exp_wdata));
            chk("wr_busy", 32'(busy_out), 32'(wtab[c].exp_busy));
            chk("wr_done", 32'(done_out), 32'(wtab[c].exp_done));
            chk("wr_out_valid", 32'(out_valid_out), 32'd0);
        end
        in_valid_in = 1'b0;
        in_data_in  = '0;

        // Unstalled read burst: five beats, surplus lane of the last beat is zero.
        @(negedge clock_in);
        start_in = 1'b1; mode_in = 2'b00; out_ready_in = 1'b1;
        #1 chk("rd_valid_idle", 32'(out_valid_out), 32'd0);
        for (int b = 0; b < 5; b++) begin
            @(negedge clock_in);
            start_in = 1'b0;
            #1;
            chk("rd_valid", 32'(out_valid_out), 32'd1);
            chk("rd_raddr", 32'(rf_read_address_out), 32'(raddr_exp(b)));
            chk("rd_odata", 32'(out_data_out), 32'(odata_exp(b)));
            chk("rd_busy", 32'(busy_out), 32'd1);
        end
        @(negedge clock_in);
        #1;
        chk("rd_valid_end", 32'(out_valid_out), 32'd0);
        chk("rd_busy_end", 32'(busy_out), 32'd0);
        chk("rd_done_early", 32'(done_out), 32'd0);
        @(negedge clock_in);
        #1 chk("rd_done", 32'(done_out), 32'd1);

        // Read with consumer stalls: ready pattern 1,0,0 repeating.
        @(negedge clock_in);
        start_in = 1'b1; mode_in = 2'b00; out_ready_in = 1'b0;
        eb = 0; hs = 0; dcount = 0; dcyc = -1;
        for (int k = 0; k < 16; k++) begin
            @(negedge clock_in);
            start_in = 1'b0;
            out_ready_in = (k % 3 == 0);
            #1;
            chk("st_valid", 32'(out_valid_out), 32'(eb < 5));
            chk("st_raddr", 32'(rf_read_address_out), 32'(raddr_exp(eb)));
            chk("st_odata", 32'(out_data_out), 32'(odata_exp(eb)));
            if (done_out) begin
                dcount++;
                dcyc = k;
            end
            if (out_valid_out && out_ready_in) hs++;
            if (eb < 5 && out_ready_in) eb++;
        end
        chk("st_handshakes", 32'(hs), 32'd5);
        chk("st_done_count", 32'(dcount), 32'd1);
        chk("st_done_cycle", 32'(dcyc), 32'd14);

        // Read+write: write stalls in cycles 4..6, read runs freely.
        @(negedge clock_in);
        start_in = 1'b1; mode_in = 2'b10; in_valid_in = 1'b0; out_ready_in = 1'b1;
        wb = 0; rb = 0;
        for (int k = 1; k <= 16; k++) begin
            @(negedge clock_in);
            start_in = 1'b0;
            in_valid_in = !(k >= 4 && k <= 6);
            wd = (wb < 9) ? wpack(wb) : 16'h0;
            in_data_in = wd;
            #1;
            chk("rw_ready", 32'(in_ready_out), 32'(wb < 9));
            chk("rw_we", 32'(rf_write_enable_out), (in_valid_in && wb < 9) ? 32'd3 : 32'd0);
            chk("rw_waddr", 32'(rf_write_address_out), (wb < 9) ? 32'(waddr_exp(wb)) : 32'd0);
            chk("rw_wdata", 32'(rf_write_data_out), 32'(wd));
            chk("rw_valid", 32'(out_valid_out), 32'(rb < 5));
            chk("rw_raddr", 32'(rf_read_address_out), 32'(raddr_exp(rb)));
            chk("rw_odata", 32'(out_data_out), 32'(odata_exp(rb)));
            chk("rw_busy", 32'(busy_out), 32'(k <= 12));
            chk("rw_done", 32'(done_out), 32'(k == 14));
            if (in_valid_in && wb < 9) wb++;
            if (rb < 5) rb++;
        end
        in_valid_in = 1'b0;
        in_data_in = '0;

        // Abort on write beat 4, then a fresh burst restarts at address 0.
        @(negedge clock_in);
        start_in = 1'b1; mode_in = 2'b01; in_valid_in = 1'b1; in_data_in = wpack(0);
        #1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clock_in);
            start_in = 1'b0;
            in_data_in = wpack(k - 1);
            #1;
            chk("ab_we", 32'(rf_write_enable_out), 32'd3);
            chk("ab_waddr", 32'(rf_write_address_out), 32'(waddr_exp(k - 1)));
        end
        @(negedge clock_in);
        abort_in = 1'b1;
        in_data_in = wpack(4);
        #1;
        chk("ab_we_abort", 32'(rf_write_enable_out), 32'd0);
        chk("ab_ready_abort", 32'(in_ready_out), 32'd0);
        chk("ab_busy_abort", 32'(busy_out), 32'd1);
        @(negedge clock_in);
        abort_in = 1'b0; in_valid_in = 1'b0;
        #1;
        chk("ab_busy_after", 32'(busy_out), 32'd0);
        chk("ab_no_done", 32'(done_out), 32'd0);
        @(negedge clock_in);
        #1 chk("ab_no_done2", 32'(done_out), 32'd0);
        @(negedge clock_in);
        start_in = 1'b1; mode_in = 2'b01; in_valid_in = 1'b1; in_data_in = wpack(0);
        #1;
        @(negedge clock_in);
        start_in = 1'b0;
        #1;
        chk("ab_restart_we", 32'(rf_write_enable_out), 32'd3);
        chk("ab_restart_waddr", 32'(rf_write_address_out), 32'(waddr_exp(0)));
        chk("ab_restart_busy", 32'(busy_out), 32'd1);
        @(negedge clock_in);
        abort_in = 1'b1;
        #1;
        @(negedge clock_in);
        abort_in = 1'b0; in_valid_in = 1'b0;
        #1 chk("ab2_busy", 32'(busy_out), 32'd0);

        // Abort in IDLE takes priority over start.
        @(negedge clock_in);
        start_in = 1'b1; mode_in = 2'b01; abort_in = 1'b1;
        #1;
        @(negedge clock_in);
        start_in = 1'b0; abort_in = 1'b0;
        #1 chk("abort_beats_start", 32'(busy_out), 32'd0);

        // Reserved mode: single-cycle error pulse, no burst.
        @(negedge clock_in);
        start_in = 1'b1; mode_in = 2'b11;
        #1 chk("err_pre", 32'(error_out), 32'd0);
        @(negedge clock_in);
        start_in = 1'b0;
        #1;
        chk("err_pulse", 32'(error_out), 32'd1);
        chk("err_busy", 32'(busy_out), 32'd0);
        @(negedge clock_in);
        #1;
        chk("err_clear", 32'(error_out), 32'd0);
        chk("err_busy2", 32'(busy_out), 32'd0);

        // Asynchronous reset during a stalled read clears outputs before the next edge.
        @(negedge clock_in);
        start_in = 1'b1; mode_in = 2'b00; out_ready_in = 1'b0;
        #1;
        @(negedge clock_in);
        start_in = 1'b0;
        #1;
        chk("ar_valid_pre", 32'(out_valid_out), 32'd1);
        chk("ar_raddr_pre", 32'(rf_read_address_out), 32'(raddr_exp(0)));
        reset_in = 1'b1;
        #1 chk_zero("async_reset");
        @(negedge clock_in);
        reset_in = 1'b0;
        #1 chk("ar_busy_post", 32'(busy_out), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
